// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register map, IE bit, FSM encoding.
package int_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned IE_BIT = 15;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_VBASE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Peripheral/register/PC-side signal bundle of the interrupt controller.
interface int_ctrl_if #(parameter int unsigned NIRQ = 8) ();

  logic [NIRQ-1:0] IRQ;
  logic            WE;
  logic [1:0]      Addr;
  logic [15:0]     Din;
  logic [15:0]     Dout;
  logic            Boundary;
  logic            PCpp;
  logic            Ret;
  logic            Reti;
  logic            INTjmp;
  logic [15:0]     Aint;
  logic            INTsave;

  modport master (
    output IRQ, WE, Addr, Din, Boundary, PCpp, Ret, Reti,
    input  Dout, INTjmp, Aint, INTsave
  );

  modport slave (
    input  IRQ, WE, Addr, Din, Boundary, PCpp, Ret, Reti,
    output Dout, INTjmp, Aint, INTsave
  );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 wins.
module int_prio_enc #(
  parameter int unsigned NIRQ = 8
) (
  input  logic [NIRQ-1:0] req,
  output logic            valid,
  output logic [3:0]      id
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller feeding the PC: latches edge requests, masks, prioritises,
// and hands one vector at a time to the PC until return-from-interrupt.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NIRQ      = 8,
  parameter int unsigned VEC_SHIFT = 2
) (
  input  logic     CLK,
  input  logic     RST,
  int_ctrl_if.slave bus
);

  state_t              state, state_n;
  logic [NIRQ-1:0]     irq_q, pend, pend_n, mask;
  logic                ie;
  logic [DATA_W-1:0]   vbase, aint, aint_n;
  logic [ID_W-1:0]     id, id_n, sel_id;
  logic                active, active_n, intjmp, intjmp_n, intsave, intsave_n;
  logic                sel_valid;
  logic [NIRQ-1:0]     eligible, rise, w1c, take;

  assign rise     = bus.IRQ & ~irq_q;
  assign w1c      = (bus.WE && bus.Addr == ADDR_PEND) ? bus.Din[NIRQ-1:0] : '0;
  assign eligible = ie ? (pend & mask) : '0;

  int_prio_enc #(.NIRQ(NIRQ)) u_enc (
    .req   (eligible),
    .valid (sel_valid),
    .id    (sel_id)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state;
    intjmp_n  = intjmp;
    aint_n    = aint;
    intsave_n = 1'b0;
    id_n      = id;
    active_n  = active;
    take      = '0;
    unique case (state)
      ST_IDLE: begin
        if (sel_valid && bus.Boundary) begin
          state_n   = ST_REQ;
          intjmp_n  = 1'b1;
          intsave_n = 1'b1;
          id_n      = sel_id;
          aint_n    = vbase + (DATA_W'(sel_id) << VEC_SHIFT);
          take      = NIRQ'(1) << sel_id;
        end
      end
      // PC gives PCpp/Ret priority over the jump, so wait for both low.
      ST_REQ: begin
        if (!bus.PCpp && !bus.Ret) begin
          state_n  = ST_SERVICE;
          intjmp_n = 1'b0;
          active_n = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.Reti) begin
          state_n  = ST_IDLE;
          active_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A new edge beats a same-cycle clear of the same bit.
  assign pend_n = (pend & ~w1c & ~take) | rise;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      irq_q   <= '0;
      pend    <= '0;
      mask    <= '0;
      ie      <= 1'b0;
      vbase   <= '0;
      aint    <= '0;
      id      <= '0;
      active  <= 1'b0;
      intjmp  <= 1'b0;
      intsave <= 1'b0;
    end else begin
      state   <= state_n;
      irq_q   <= bus.IRQ;
      pend    <= pend_n;
      aint    <= aint_n;
      id      <= id_n;
      active  <= active_n;
      intjmp  <= intjmp_n;
      intsave <= intsave_n;
      if (bus.WE && bus.Addr == ADDR_CTRL) begin
        mask <= bus.Din[NIRQ-1:0];
        ie   <= bus.Din[IE_BIT];
      end
      if (bus.WE && bus.Addr == ADDR_VBASE) vbase <= bus.Din;
    end
  end

  assign bus.INTjmp  = intjmp;
  assign bus.Aint    = aint;
  assign bus.INTsave = intsave;

  always_comb begin
    bus.Dout = '0;
    unique case (bus.Addr)
      ADDR_CTRL: begin
        bus.Dout         = DATA_W'(mask);
        bus.Dout[IE_BIT] = ie;
      end
      ADDR_PEND:   bus.Dout = DATA_W'(pend);
      ADDR_VBASE:  bus.Dout = vbase;
      ADDR_STATUS: bus.Dout = {active, 11'b0, id};
      default:     bus.Dout = '0;
    endcase
  end

endmodule
